// File: rtl/sct_stage_responder.sv
// Far-end responder for the stage-scan control interface: validates grants, runs per-stage busy
// intervals, returns a completion thermometer. Optional ARM watchdog enabled by SCT_RSP_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start, all status clear
// ARM   | waiting for the grant of the next stage index
// RUN   | stage executing, busy counter running
// ACK   | one-cycle completion pulse
// WREL  | waiting for the controller to release the grant
// DONE  | all stages complete
// ERR   | illegal grant or watchdog expiry, err_code held

module sct_stage_responder #(
    parameter int STAGES      = 8,
    parameter int BUSY_CYCLES = 3,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [STAGES-1:0] grant,
    output logic [STAGES-1:0] done_flags,
    output logic              busy,
    output logic              ack,
    output logic              seq_done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_WREL = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [1:0] EC_NONE    = 2'b00;
    localparam logic [1:0] EC_ONEHOT  = 2'b01;
    localparam logic [1:0] EC_ORDER   = 2'b10;
    localparam logic [1:0] EC_TIMEOUT = 2'b11;

    localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
    localparam int IDX_W = $clog2(STAGES + 1);

    logic [2:0]        state_q, state_d;
    logic [STAGES-1:0] flags_q, flags_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              seq_done_q, seq_done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [IDX_W-1:0]  next_idx;
    logic [STAGES-1:0] expect_grant;
    logic              grant_zero;
    logic              grant_onehot;
    logic              all_done;
    logic              wdog_expired;

    // Flags form a thermometer, so the population count is the index of the next stage.
    always_comb begin
        next_idx = '0;
        for (int i = 0; i < STAGES; i++) begin
            next_idx = next_idx + IDX_W'(flags_q[i]);
        end
    end

    assign expect_grant = STAGES'(1) << next_idx;
    assign grant_zero   = (grant == '0);
    assign grant_onehot = !grant_zero && ((grant & (grant - STAGES'(1))) == '0);
    assign all_done     = &flags_q;

`ifdef SCT_RSP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d       = wdog_q;
        wdog_expired = 1'b0;
        if (state_q == S_ARM) begin
            if (grant_zero && !hold) begin
                wdog_expired = (wdog_q == WD_W'(TIMEOUT - 1));
                wdog_d       = wdog_q + WD_W'(1);
            end
        end else begin
            wdog_d = '0;
        end
        if (abort) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;

    assign wdog_expired = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        seq_done_d = seq_done_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    flags_d = '0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (!grant_zero) begin
                    if (!grant_onehot) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = EC_ONEHOT;
                    end else if (grant != expect_grant) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        err_code_d = EC_ORDER;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(BUSY_CYCLES);
                        busy_d  = 1'b1;
                    end
                end else if (wdog_expired) begin
                    state_d    = S_ERR;
                    err_d      = 1'b1;
                    err_code_d = EC_TIMEOUT;
                end
            end
            S_RUN: begin
                // Stage is flagged on the same edge busy drops, so busy spans BUSY_CYCLES cycles.
                if (!hold) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_ACK;
                        flags_d = flags_q | expect_grant;
                        busy_d  = 1'b0;
                        ack_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_ACK: begin
                if (all_done) begin
                    state_d    = S_DONE;
                    seq_done_d = 1'b1;
                end else begin
                    state_d = S_WREL;
                end
            end
            S_WREL: begin
                if (grant_zero) begin
                    state_d = S_ARM;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d    = S_ARM;
                    flags_d    = '0;
                    seq_done_d = 1'b0;
                end
            end
            S_ERR: begin
                if (start) begin
                    state_d    = S_ARM;
                    flags_d    = '0;
                    err_d      = 1'b0;
                    err_code_d = EC_NONE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                flags_d    = '0;
                cnt_d      = '0;
                busy_d     = 1'b0;
                seq_done_d = 1'b0;
                err_d      = 1'b0;
                err_code_d = EC_NONE;
            end
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            flags_d    = '0;
            cnt_d      = '0;
            busy_d     = 1'b0;
            ack_d      = 1'b0;
            seq_done_d = 1'b0;
            err_d      = 1'b0;
            err_code_d = EC_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            flags_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= EC_NONE;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign done_flags = flags_q;
    assign busy       = busy_q;
    assign ack        = ack_q;
    assign seq_done   = seq_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_sct_stage_responder.sv
// Directed bench for sct_stage_responder: full sequence, grant errors, hold, abort, async reset, watchdog.

module tb_sct_stage_responder;

    localparam int STAGES = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              hold;
    logic [STAGES-1:0] grant;
    logic [STAGES-1:0] done_flags;
    logic              busy;
    logic              ack;
    logic              seq_done;
    logic              err;
    logic [1:0]        err_code;

    int n_tests = 0;
    int n_fail  = 0;

    sct_stage_responder #(
        .STAGES      (STAGES),
        .BUSY_CYCLES (3),
        .TIMEOUT     (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .hold       (hold),
        .grant      (grant),
        .done_flags (done_flags),
        .busy       (busy),
        .ack        (ack),
        .seq_done   (seq_done),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flags"}, 32'(done_flags), 32'h0);
        check_eq({tag, "_busy"}, 32'(busy), 32'h0);
        check_eq({tag, "_ack"}, 32'(ack), 32'h0);
        check_eq({tag, "_seqdone"}, 32'(seq_done), 32'h0);
        check_eq({tag, "_err"}, 32'(err), 32'h0);
        check_eq({tag, "_errcode"}, 32'(err_code), 32'h0);
    endtask

    // Grant stage k from ARM, count busy cycles, check the ack and flags, then release the grant.
    task automatic run_stage(input int k, input bit use_hold, input logic [7:0] exp_flags,
                             input int exp_busy);
        int busy_cnt;
        grant = 8'h01 << k;
        tick();
        busy_cnt = 0;
        while (busy && busy_cnt < 40) begin
            busy_cnt++;
            hold = use_hold && (busy_cnt >= 1) && (busy_cnt <= 4);
            tick();
        end
        hold = 1'b0;
        check_eq($sformatf("s%0d_busy_cycles", k), 32'(busy_cnt), 32'(exp_busy));
        check_eq($sformatf("s%0d_ack", k), 32'(ack), 32'h1);
        check_eq($sformatf("s%0d_flags", k), 32'(done_flags), 32'(exp_flags));
        grant = '0;
        tick();
        check_eq($sformatf("s%0d_ack_pulse", k), 32'(ack), 32'h0);
        if (exp_flags != 8'hFF) begin
            tick();
        end
    endtask

    initial begin
        logic [7:0] flags_exp;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        grant = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Full eight-stage sequence
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("arm_flags", 32'(done_flags), 32'h0);
        flags_exp = 8'h00;
        for (int k = 0; k < STAGES; k++) begin
            flags_exp = flags_exp | (8'h01 << k);
            run_stage(k, 1'b0, flags_exp, 3);
        end
        check_eq("seq_done", 32'(seq_done), 32'h1);
        check_eq("seq_flags", 32'(done_flags), 32'hFF);

        // Out-of-order grant after two stages
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("restart_seqdone", 32'(seq_done), 32'h0);
        check_eq("restart_flags", 32'(done_flags), 32'h0);
        run_stage(0, 1'b0, 8'h01, 3);
        run_stage(1, 1'b0, 8'h03, 3);
        grant = 8'h08;
        tick();
        check_eq("order_err", 32'(err), 32'h1);
        check_eq("order_code", 32'(err_code), 32'h2);
        check_eq("order_flags", 32'(done_flags), 32'h03);
        grant = '0;
        tick();
        check_eq("order_hold_code", 32'(err_code), 32'h2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("clr_err", 32'(err), 32'h0);
        check_eq("clr_code", 32'(err_code), 32'h0);
        check_eq("clr_flags", 32'(done_flags), 32'h0);

        // Non-one-hot grant
        grant = 8'h05;
        tick();
        check_eq("onehot_err", 32'(err), 32'h1);
        check_eq("onehot_code", 32'(err_code), 32'h1);
        check_eq("onehot_busy", 32'(busy), 32'h0);
        check_eq("onehot_ack", 32'(ack), 32'h0);
        grant = '0;
        start = 1'b1;
        tick();
        start = 1'b0;

        // Hold mid-RUN stretches busy to 7 cycles
        run_stage(0, 1'b1, 8'h01, 7);

        // abort with start during RUN of stage 3
        run_stage(1, 1'b0, 8'h03, 3);
        run_stage(2, 1'b0, 8'h07, 3);
        grant = 8'h08;
        tick();
        check_eq("s3_busy", 32'(busy), 32'h1);
        tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_all_zero("abort");
        grant = 8'h01;
        tick();
        check_eq("idle_ignores_grant", 32'(busy), 32'h0);
        grant = '0;

        // Asynchronous reset mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        run_stage(0, 1'b0, 8'h01, 3);
        grant = 8'h02;
        tick();
        check_eq("pre_rst_busy", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        grant = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Watchdog behaviour
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef SCT_RSP_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check_eq("wd_pre_err", 32'(err), 32'h0);
        tick();
        check_eq("wd_err", 32'(err), 32'h1);
        check_eq("wd_code", 32'(err_code), 32'h3);
`else
        for (int i = 0; i < 100; i++) tick();
        check_eq("nowd_err", 32'(err), 32'h0);
        check_eq("nowd_code", 32'(err_code), 32'h0);
        grant = 8'h01;
        tick();
        check_eq("nowd_still_arm", 32'(busy), 32'h1);
        grant = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
